ripple_carry_adder: RTL and testbench
=====================================

// Module: ripple_carry_adder
// PURPOSE
//   N-bit unsigned adder built as a chain of 1-bit full adders; carry ripples LSB->MSB.
//   Sum/carry outputs are combinational (zero latency) for datapath use.
//   A registered copy of the result is provided for pipelined consumers.
//   Leaf arithmetic block, instantiated wherever a small carry-in adder is needed.
// PARAMETERS
//   WIDTH  4  operand/sum bit width; legal range 1..64
// PORTS
//   clk     in   1      single clock; rising edge; clocks only the registered outputs
//   rst     in   1      synchronous, active-high reset; clears registered outputs only
//   a       in   WIDTH  operand A, unsigned
//   b       in   WIDTH  operand B, unsigned
//   cin     in   1      carry into bit 0
//   s       out  WIDTH  combinational sum, {cout,s} = a + b + cin
//   cout    out  1      combinational carry out of bit WIDTH-1
//   ovf     out  1      combinational signed overflow = carry into MSB XOR cout
//   s_q     out  WIDTH  s registered on clk
//   cout_q  out  1      cout registered on clk
//   ovf_q   out  1      ovf registered on clk
// BEHAVIOUR
//   - Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
//   - Combinational path:
//     - {cout,s} == a + b + cin exactly, for all 2^(2*WIDTH+1) input combinations.
//     - Bit i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = cin; cout = c[WIDTH].
//     - Outputs settle with inputs; no clock dependence.
//     - X/Z on any input may propagate to the outputs; no masking.
//   - Registered path:
//     - On posedge clk, if rst then s_q <= 0, cout_q <= 0, ovf_q <= 0.
//     - Otherwise s_q/cout_q/ovf_q <= current s/cout/ovf; latency exactly 1 cycle.
//     - rst does not affect s/cout/ovf; the combinational result stays valid during reset.
//     - Reset asserted mid-stream clears the registers on that edge.
//     - The first post-reset edge captures the live inputs.
//   - Boundaries:
//     - Wrap-around: a=b=all-ones, cin=1 gives s=all-ones, cout=1.
//     - Zero: a=b=0, cin=0 gives s=0, cout=0, ovf=0.
//     - Signed overflow: ovf=1 when a and b have the same MSB and s has a different MSB.
//   - No handshake and no state machine; every input is sampled continuously.
// STRUCTURE
//   - Sub-module full_adder (a, b, ci -> s, co), purely combinational.
//   - Generate loop instantiates WIDTH copies of full_adder; internal carry vector is WIDTH+1 bits.
//   - One always_ff block for the output registers.
//   - Shared package: default width constant RCA_WIDTH_DEFAULT = 4 only; no typedefs needed.
// TESTING
//   1. Exhaustive, WIDTH=4, cin=0: sweep a=0..15 and b=0..15 with 1 ns settle each.
//      Required: {cout,s} == a+b for all 256 pairs.
//   2. Exhaustive repeat with cin=1.
//      Required: {cout,s} == a+b+1; e.g. a=15, b=15 -> s=15, cout=1.
//   3. Overflow: a=4'h7, b=4'h1, cin=0 -> s=4'h8, cout=0, ovf=1.
//      a=4'h8, b=4'h8 -> s=0, cout=1, ovf=1.
//   4. Registered latency: apply a=3, b=5, cin=0 with rst=0.
//      Required: s=8 immediately; s_q=8 after the next posedge, not before.
//   5. Reset: hold rst=1 over 2 edges with a=9, b=9.
//      Required: s_q=0, cout_q=0, ovf_q=0, while s=2, cout=1 stay live.
//      Deassert rst: s_q=2 after 1 edge.
//   6. WIDTH=8 random: 10k vectors.
//      Required: {cout,s} == a+b+cin; ovf matches signed reference model.

Source files
------------

// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
package ripple_carry_adder_pkg;
    localparam int RCA_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// 1-bit full adder leaf cell, purely combinational.
// Latency: zero; no backpressure (no handshake).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

// File: rtl/ripple_carry_adder.sv
// Unsigned ripple-carry adder with combinational and registered result copies.
// Latency: s/cout/ovf zero, s_q/cout_q/ovf_q one clk; no backpressure (no handshake).
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             ovf_q
);
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[WIDTH];
    // Carry into the MSB differing from carry out of it flags two's-complement overflow.
    assign ovf  = c[WIDTH-1] ^ c[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s_q    <= s;
            cout_q <= cout;
            ovf_q  <= ovf;
        end
    end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed and randomized self-checking bench for ripple_carry_adder (WIDTH 4 and 8).
module tb_ripple_carry_adder;
    logic       clk;
    logic       rst;
    logic [3:0] a, b, s, s_q;
    logic       cin, cout, ovf, cout_q, ovf_q;
    logic [7:0] a8, b8, s8, s8_q;
    logic       cin8, cout8, ovf8, cout8_q, ovf8_q;

    int checks;
    int failures;

    ripple_carry_adder #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .s      (s),
        .cout   (cout),
        .ovf    (ovf),
        .s_q    (s_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    ripple_carry_adder #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .a      (a8),
        .b      (b8),
        .cin    (cin8),
        .s      (s8),
        .cout   (cout8),
        .ovf    (ovf8),
        .s_q    (s8_q),
        .cout_q (cout8_q),
        .ovf_q  (ovf8_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [8:0] e9;
        int         sa;
        logic       ovf_exp;

        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        a    = 4'h0; b  = 4'h0; cin  = 1'b0;
        a8   = 8'h0; b8 = 8'h0; cin8 = 1'b0;

        // Reset state and zero boundary
        @(posedge clk); #1;
        check("rst_s_q",     64'(s_q),    64'h0);
        check("rst_cout_q",  64'(cout_q), 64'h0);
        check("rst_ovf_q",   64'(ovf_q),  64'h0);
        check("rst_s8_q",    64'(s8_q),   64'h0);
        check("zero_s",      64'(s),      64'h0);
        check("zero_cout",   64'(cout),   64'h0);
        check("zero_ovf",    64'(ovf),    64'h0);

        // Exhaustive sweeps, cin=0 then cin=1
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    int e;
                    a   = i[3:0];
                    b   = j[3:0];
                    cin = c[0];
                    e   = i + j + c;
                    #1;
                    check(c == 0 ? "exh_cin0" : "exh_cin1", 64'({cout, s}), 64'(e[4:0]));
                end
            end
        end

        // Wrap-around
        a = 4'hF; b = 4'hF; cin = 1'b1; #1;
        check("wrap_s",    64'(s),    64'hF);
        check("wrap_cout", 64'(cout), 64'h1);

        // Signed overflow
        a = 4'h7; b = 4'h1; cin = 1'b0; #1;
        check("ovf_pos_s",    64'(s),    64'h8);
        check("ovf_pos_cout", 64'(cout), 64'h0);
        check("ovf_pos_ovf",  64'(ovf),  64'h1);
        a = 4'h8; b = 4'h8; cin = 1'b0; #1;
        check("ovf_neg_s",    64'(s),    64'h0);
        check("ovf_neg_cout", 64'(cout), 64'h1);
        check("ovf_neg_ovf",  64'(ovf),  64'h1);
        a = 4'h3; b = 4'h2; #1;
        check("no_ovf", 64'(ovf), 64'h0);

        // Registered latency: capture happens only at the next edge
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0; a = 4'h3; b = 4'h5; cin = 1'b0;
        #1;
        check("lat_s_now",   64'(s),   64'h8);
        check("lat_s_q_pre", 64'(s_q), 64'h0);
        @(posedge clk); #1;
        check("lat_s_q_post", 64'(s_q), 64'h8);
        check("lat_ovf_q",    64'(ovf_q), 64'h1);

        // Reset held over two edges while combinational result stays live
        @(negedge clk);
        rst = 1'b1; a = 4'h9; b = 4'h9; cin = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("rsth_s_q",    64'(s_q),    64'h0);
            check("rsth_cout_q", 64'(cout_q), 64'h0);
            check("rsth_ovf_q",  64'(ovf_q),  64'h0);
            check("rsth_s",      64'(s),      64'h2);
            check("rsth_cout",   64'(cout),   64'h1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_s_q",    64'(s_q),    64'h2);
        check("rel_cout_q", 64'(cout_q), 64'h1);
        check("rel_ovf_q",  64'(ovf_q),  64'h1);

        // WIDTH=8 random vectors against an arithmetic reference
        for (int n = 0; n < 10000; n++) begin
            a8   = 8'($urandom_range(0, 255));
            b8   = 8'($urandom_range(0, 255));
            cin8 = 1'($urandom_range(0, 1));
            #1;
            e9 = {1'b0, a8} + {1'b0, b8} + {8'h0, cin8};
            sa = int'($signed(a8)) + int'($signed(b8)) + int'(cin8);
            ovf_exp = (sa > 127) || (sa < -128);
            check("w8_sum", 64'({cout8, s8}), 64'(e9));
            check("w8_ovf", 64'(ovf8),        64'(ovf_exp));
        end

        // WIDTH=8 registered path
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(posedge clk); #1;
        check("w8_s_q",    64'(s8_q),    64'hFF);
        check("w8_cout_q", 64'(cout8_q), 64'h1);
        check("w8_ovf_q",  64'(ovf8_q),  64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
